// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration limits for the bit-serial adder controller.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MIN_WIDTH = 32'sd2;
    localparam int MAX_WIDTH = 32'sd32;

endpackage

// File: rtl/serial_adder_ctrl_full_adder_bit.sv
// Single-bit full adder assembled from two half adders; the carries are ORed
// because both half-adder carries can never be set at the same time.
module half_adder (
    input  logic i_bit1,
    input  logic i_bit2,
    output logic o_sum,
    output logic o_carry
);

    assign o_sum   = i_bit1 ^ i_bit2;
    assign o_carry = i_bit1 & i_bit2;

endmodule

module full_adder_bit (
    input  logic i_bit1,
    input  logic i_bit2,
    input  logic i_carry,
    output logic o_sum,
    output logic o_carry
);

    logic ha0_sum_s;
    logic ha0_carry_s;
    logic ha1_carry_s;

    half_adder u_ha0 (
        .i_bit1  (i_bit1),
        .i_bit2  (i_bit2),
        .o_sum   (ha0_sum_s),
        .o_carry (ha0_carry_s)
    );

    half_adder u_ha1 (
        .i_bit1  (ha0_sum_s),
        .i_bit2  (i_carry),
        .o_sum   (o_sum),
        .o_carry (ha1_carry_s)
    );

    assign o_carry = ha0_carry_s | ha1_carry_s;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell is stepped LSB-first over
// WIDTH cycles; the result is held in output registers until the next completion.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_operand_a,
    input  logic [WIDTH-1:0] i_operand_b,
    output logic             o_ready,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'sd1);

    if ((WIDTH < MIN_WIDTH) || (WIDTH > MAX_WIDTH)) begin : g_width_bad
        $error("serial_adder_ctrl: WIDTH out of range");
    end

    state_t             state_r;
    state_t             state_nxt_s;
    logic               accept_s;
    logic               last_bit_s;
    logic [WIDTH-1:0]   shift_a_r;
    logic [WIDTH-1:0]   shift_b_r;
    // Only WIDTH-1 bits are kept: the newest bit arrives via acc_nxt_s.
    logic [WIDTH-2:0]   acc_r;
    logic [WIDTH-1:0]   acc_nxt_s;
    logic               carry_r;
    logic [CNT_W-1:0]   bit_cnt_r;
    logic [WIDTH-1:0]   sum_r;
    logic               carry_out_r;
    logic               fa_sum_s;
    logic               fa_carry_s;

    full_adder_bit u_fa (
        .i_bit1  (shift_a_r[0]),
        .i_bit2  (shift_b_r[0]),
        .i_carry (carry_r),
        .o_sum   (fa_sum_s),
        .o_carry (fa_carry_s)
    );

    assign acc_nxt_s  = {fa_sum_s, acc_r};
    assign last_bit_s = (bit_cnt_r == CNT_LAST);

    // Next-state decode and request acceptance.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_start) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ADD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ADD: begin
                if (last_bit_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = ADD;
                end
            end
            DONE: begin
                if (i_start) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ADD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Serial datapath: operand shifters, carry flop, accumulator and result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shift_a_r   <= '0;
            shift_b_r   <= '0;
            acc_r       <= '0;
            carry_r     <= 1'b0;
            bit_cnt_r   <= '0;
            sum_r       <= '0;
            carry_out_r <= 1'b0;
        end else if (accept_s) begin
            shift_a_r <= i_operand_a;
            shift_b_r <= i_operand_b;
            acc_r     <= '0;
            carry_r   <= 1'b0;
            bit_cnt_r <= '0;
        end else if (state_r == ADD) begin
            shift_a_r <= {1'b0, shift_a_r[WIDTH-1:1]};
            shift_b_r <= {1'b0, shift_b_r[WIDTH-1:1]};
            acc_r     <= acc_nxt_s[WIDTH-1:1];
            carry_r   <= fa_carry_s;
            bit_cnt_r <= bit_cnt_r + CNT_ONE;
            if (last_bit_s) begin
                sum_r       <= acc_nxt_s;
                carry_out_r <= fa_carry_s;
            end
        end
    end

    assign o_sum   = sum_r;
    assign o_carry = carry_out_r;
    assign o_done  = (state_r == DONE);
    assign o_busy  = (state_r == ADD);
    assign o_ready = (state_r == IDLE) || (state_r == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: expected sums are queued on issue
// and popped when o_done is observed.
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             i_clk;
    logic             i_rst;
    logic             i_start;
    logic [WIDTH-1:0] i_operand_a;
    logic [WIDTH-1:0] i_operand_b;
    logic             o_ready;
    logic             o_busy;
    logic [WIDTH-1:0] o_sum;
    logic             o_carry;
    logic             o_done;

    logic [WIDTH:0]   exp_q[$];
    logic [WIDTH:0]   exp_v;
    int               checks;
    int               errors;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_operand_a (i_operand_a),
        .i_operand_b (i_operand_b),
        .o_ready     (o_ready),
        .o_busy      (o_busy),
        .o_sum       (o_sum),
        .o_carry     (o_carry),
        .o_done      (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Drive one request sampled at the next rising edge (edge 0), then drop start.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge i_clk);
        i_start     = 1'b1;
        i_operand_a = a;
        i_operand_b = b;
        exp_q.push_back({1'b0, a} + {1'b0, b});
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    // Count falling edges until o_done; n=k means done sampled at edge k.
    task automatic wait_done(output int n, output bit seen);
        n    = 0;
        seen = 1'b0;
        for (int c = 0; c < 3 * WIDTH; c++) begin
            @(negedge i_clk);
            n++;
            if (o_done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic pop_exp(output logic [WIDTH:0] v);
        if (exp_q.size() > 0) v = exp_q.pop_front();
        else v = 'x;
    endtask

    task automatic test_reset;
        i_rst = 1'b1; i_start = 1'b0; i_operand_a = '0; i_operand_b = '0;
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        checks += 5;
        if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", o_ready); end
        if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
        if (o_sum !== 8'h00) begin errors++; $display("FAIL reset_sum got %h want 00", o_sum); end
        if (o_carry !== 1'b0) begin errors++; $display("FAIL reset_carry got %b want 0", o_carry); end
        if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", o_done); end
    endtask

    task automatic test_basic;
        issue(8'h35, 8'h4A);
        for (int e = 1; e <= 8; e++) begin
            @(negedge i_clk);
            checks++;
            if (o_busy !== 1'b1 || o_done !== 1'b0 || o_sum !== 8'h00) begin
                errors++;
                $display("FAIL basic_busy edge %0d got busy=%b done=%b sum=%h want busy=1 done=0 sum=00",
                         e, o_busy, o_done, o_sum);
            end
        end
        @(negedge i_clk);
        pop_exp(exp_v);
        checks += 2;
        if (o_done !== 1'b1) begin errors++; $display("FAIL basic_done edge 9 got %b want 1", o_done); end
        if ({o_carry, o_sum} !== exp_v) begin
            errors++; $display("FAIL basic_sum got %h want %h", {o_carry, o_sum}, exp_v);
        end
        @(negedge i_clk);
        checks++;
        if (o_done !== 1'b0 || o_ready !== 1'b1) begin
            errors++; $display("FAIL basic_after got done=%b ready=%b want done=0 ready=1", o_done, o_ready);
        end
    endtask

    task automatic test_ripple;
        logic [WIDTH-1:0] ta[2];
        logic [WIDTH-1:0] tb[2];
        int n;
        bit seen;
        ta[0] = 8'hFF; tb[0] = 8'h01;
        ta[1] = 8'hFF; tb[1] = 8'hFF;
        for (int t = 0; t < 2; t++) begin
            issue(ta[t], tb[t]);
            wait_done(n, seen);
            pop_exp(exp_v);
            checks += 2;
            if (!seen || n != 9) begin errors++; $display("FAIL ripple_latency got %0d seen=%b want 9", n, seen); end
            if ({o_carry, o_sum} !== exp_v) begin
                errors++; $display("FAIL ripple_sum got %h want %h", {o_carry, o_sum}, exp_v);
            end
        end
    endtask

    task automatic test_start_busy;
        int n;
        bit seen;
        int extra;
        issue(8'h35, 8'h4A);
        repeat (3) @(negedge i_clk);
        i_start = 1'b1; i_operand_a = 8'h11;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_done(n, seen);
        pop_exp(exp_v);
        checks += 2;
        if (!seen || n != 5) begin errors++; $display("FAIL busy_latency got %0d seen=%b want 5", n, seen); end
        if ({o_carry, o_sum} !== exp_v) begin
            errors++; $display("FAIL busy_sum got %h want %h", {o_carry, o_sum}, exp_v);
        end
        extra = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge i_clk);
            if (o_done) extra++;
        end
        checks += 2;
        if (extra != 0) begin errors++; $display("FAIL busy_extra_done got %0d want 0", extra); end
        if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
            errors++; $display("FAIL busy_ready got ready=%b busy=%b want 1 0", o_ready, o_busy);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        bit seen;
        @(negedge i_clk);
        i_start = 1'b1; i_operand_a = 8'h01; i_operand_b = 8'h02;
        exp_q.push_back({1'b0, i_operand_a} + {1'b0, i_operand_b});
        @(posedge i_clk);
        #1;
        wait_done(n, seen);
        pop_exp(exp_v);
        checks += 2;
        if (!seen || n != 9) begin errors++; $display("FAIL b2b_first_latency got %0d want 9", n); end
        if ({o_carry, o_sum} !== exp_v) begin
            errors++; $display("FAIL b2b_first_sum got %h want %h", {o_carry, o_sum}, exp_v);
        end
        i_operand_a = 8'h10; i_operand_b = 8'h20;
        exp_q.push_back({1'b0, i_operand_a} + {1'b0, i_operand_b});
        @(posedge i_clk);
        #1 i_start = 1'b0;
        wait_done(n, seen);
        pop_exp(exp_v);
        checks += 2;
        if (!seen || n != 9) begin errors++; $display("FAIL b2b_second_latency got %0d want 9", n); end
        if ({o_carry, o_sum} !== exp_v) begin
            errors++; $display("FAIL b2b_second_sum got %h want %h", {o_carry, o_sum}, exp_v);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        bit seen;
        int dones;
        issue(8'hFF, 8'h01);
        repeat (4) @(negedge i_clk);
        i_rst = 1'b1;
        void'(exp_q.pop_back());
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge i_clk);
            if (o_done) dones++;
        end
        checks += 3;
        if (dones != 0) begin errors++; $display("FAIL rst_mid_done got %0d want 0", dones); end
        if ({o_carry, o_sum} !== 9'h000) begin
            errors++; $display("FAIL rst_mid_sum got %h want 000", {o_carry, o_sum});
        end
        if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_idle got ready=%b busy=%b want 1 0", o_ready, o_busy);
        end
        issue(8'h02, 8'h03);
        wait_done(n, seen);
        pop_exp(exp_v);
        checks += 2;
        if (!seen) begin errors++; $display("FAIL rst_mid_after_timeout got 0 want 1"); end
        if ({o_carry, o_sum} !== exp_v) begin
            errors++; $display("FAIL rst_mid_after_sum got %h want %h", {o_carry, o_sum}, exp_v);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_ripple();
        test_start_busy();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
